// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the RV32I 5-stage pipeline.
//
// The stage owns the program counter (pc_f). pc_f drives the instruction
// memory address directly, and the memory returns the word in the same cycle.
// On each rising edge the stage captures the word, its PC and PC+4 into the
// IF/ID pipeline register.
//
// Hazard protocol:
//   stall          holds pc_f and the whole IF/ID register.
//   flush          replaces the IF/ID contents with a bubble.
//   redirect_valid loads pc_f from redirect_target and flushes the wrong-path
//                  fetch. It overrides stall.
//   Priority at every edge is reset > redirect/flush > stall > advance.
//   There is no valid/ready handshake on this stage.
//
// Ports:
//   clk              system clock; all state updates on the rising edge
//   reset            synchronous, active-high reset
//   stall            hold PC and IF/ID
//   flush            bubble IF/ID
//   redirect_valid   branch/jump taken
//   redirect_target  new PC byte address
//   imem_addr        byte address to instruction memory (== pc_f)
//   imem_rd          instruction word for imem_addr, same cycle
//   pc_f             current fetch PC
//   instr_d          IF/ID instruction
//   pc_d             IF/ID PC of instr_d
//   pc_plus4_d       IF/ID pc_d + 4
//   valid_d          IF/ID holds a real instruction (0 = bubble)
//   fault_d          instr_d was fetched out of range or after a misaligned
//                    redirect
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fault_d
);

  // Word-index limit, widened to match pc_f[31:2].
  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  // mis_f records that the current pc_f came from a redirect whose target
  // had nonzero low bits. The PC itself is always kept word-aligned.
  logic        mis_f;
  logic        oob_f;
  logic [31:0] pc_plus4_f;

  assign imem_addr  = pc_f;
  assign pc_plus4_f = pc_f + 32'd4;  // wraps mod 2^32
  assign oob_f      = (pc_f[31:2] >= IMEM_LIMIT);

  // Program counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f  <= RESET_PC;
      mis_f <= 1'b0;
    end else if (redirect_valid) begin
      pc_f  <= {redirect_target[31:2], 2'b00};
      mis_f <= |redirect_target[1:0];
    end else if (!stall) begin
      pc_f  <= pc_plus4_f;
      mis_f <= 1'b0;
    end
  end

  // IF/ID pipeline register. A redirect always squashes the wrong-path
  // fetch, even if the hazard unit is also stalling. A bubble keeps pc_d
  // and pc_plus4_d at their old values.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
      fault_d    <= 1'b0;
    end else if (flush || redirect_valid) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
      fault_d <= 1'b0;
    end else if (!stall) begin
      // Faulting fetches still travel as valid instructions. This lets the
      // trap logic see them in program order. Out-of-range words never
      // reach decode.
      instr_d    <= oob_f ? NOP_INSTR : imem_rd;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
      valid_d    <= 1'b1;
      fault_d    <= oob_f | mis_f;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. A behavioural 64-word instruction memory
// answers imem_addr combinationally. Each word holds a distinct pattern, and
// any address outside the memory returns a garbage word. Inputs change 1 ns
// after a rising edge, and outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] pc_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fault_d;

  int n_cmp;
  int n_err;

  logic [31:0] mem [64];

  fetch_stage #(
    .RESET_PC  (32'h00000000),
    .IMEM_WORDS(64),
    .NOP_INSTR (32'h00000013)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .pc_f           (pc_f),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d),
    .fault_d        (fault_d)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------- instruction memory
  assign imem_rd = (imem_addr[31:8] == 24'd0) ? mem[imem_addr[7:2]] : 32'hDEADBEEF;

  function automatic logic [31:0] word(input int i);
    return 32'hC0DE0000 + 32'(i);
  endfunction

  // ------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the fetch PC and the full IF/ID register.
  task automatic expect_all(input string tag, input logic [31:0] e_pc_f,
                            input logic [31:0] e_instr, input logic [31:0] e_pc_d,
                            input logic [31:0] e_p4, input logic e_valid,
                            input logic e_fault);
    check({tag, ".pc_f"},       pc_f,              e_pc_f);
    check({tag, ".imem_addr"},  imem_addr,         e_pc_f);
    check({tag, ".instr_d"},    instr_d,           e_instr);
    check({tag, ".pc_d"},       pc_d,              e_pc_d);
    check({tag, ".pc_plus4_d"}, pc_plus4_d,        e_p4);
    check({tag, ".valid_d"},    {31'd0, valid_d},  {31'd0, e_valid});
    check({tag, ".fault_d"},    {31'd0, fault_d},  {31'd0, e_fault});
  endtask

  // ------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input logic rv, input logic [31:0] rt);
    stall           = s;
    flush           = f;
    redirect_valid  = rv;
    redirect_target = rt;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = word(i);

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    tick();
    expect_all("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0);

    // Run from reset: instr_d trails pc_f by one cycle.
    reset = 1'b0;
    tick();
    expect_all("run0", 32'h4, word(0), 32'h0, 32'h4, 1'b1, 1'b0);
    tick();
    expect_all("run1", 32'h8, word(1), 32'h4, 32'h8, 1'b1, 1'b0);

    // Stall for 3 cycles at pc_f = 8.
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_all($sformatf("stall%0d", i), 32'h8, word(1), 32'h4, 32'h8, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    expect_all("unstall0", 32'hC, word(2), 32'h8, 32'hC, 1'b1, 1'b0);
    tick();
    expect_all("unstall1", 32'h10, word(3), 32'hC, 32'h10, 1'b1, 1'b0);

    // Redirect under stall at pc_f = 0x10: the redirect wins.
    drive(1'b1, 1'b0, 1'b1, 32'h40);
    tick();
    expect_all("redir_stall", 32'h40, NOP, 32'hC, 32'h10, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    expect_all("redir_after", 32'h44, word(16), 32'h40, 32'h44, 1'b1, 1'b0);

    // Move to 0x20, then flush without a redirect.
    drive(1'b0, 1'b0, 1'b1, 32'h20);
    tick();
    expect_all("goto20", 32'h20, NOP, 32'h40, 32'h44, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    expect_all("flush", 32'h24, NOP, 32'h40, 32'h44, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    expect_all("flush_after", 32'h28, word(9), 32'h24, 32'h28, 1'b1, 1'b0);

    // Stall + flush together: PC holds, IF/ID becomes a bubble.
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    expect_all("stall_flush", 32'h28, NOP, 32'h24, 32'h28, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    expect_all("stall_flush_after", 32'h2C, word(10), 32'h28, 32'h2C, 1'b1, 1'b0);

    // Misaligned redirect target 0x46.
    drive(1'b0, 1'b0, 1'b1, 32'h46);
    tick();
    expect_all("mis_redir", 32'h44, NOP, 32'h28, 32'h2C, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    expect_all("mis_fetch", 32'h48, word(17), 32'h44, 32'h48, 1'b1, 1'b1);
    tick();
    expect_all("mis_next", 32'h4C, word(18), 32'h48, 32'h4C, 1'b1, 1'b0);

    // Last in-range word (63), then sequential fetch into word 64.
    drive(1'b0, 1'b0, 1'b1, 32'hFC);
    tick();
    expect_all("edge_redir", 32'hFC, NOP, 32'h48, 32'h4C, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    expect_all("word63", 32'h100, word(63), 32'hFC, 32'h100, 1'b1, 1'b0);
    tick();
    expect_all("word64_seq", 32'h104, NOP, 32'h100, 32'h104, 1'b1, 1'b1);

    // Redirect straight to 0x100 (word 64).
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    expect_all("oob_redir", 32'h104, NOP, 32'h100, 32'h104, 1'b1, 1'b1);

    // Wrap-around at the top of the address space.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
    tick();
    check("wrap_redir.pc_f", pc_f, 32'hFFFFFFFC);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    expect_all("wrap", 32'h0, NOP, 32'hFFFFFFFC, 32'h0, 1'b1, 1'b1);
    tick();
    expect_all("wrap_next", 32'h4, word(0), 32'h0, 32'h4, 1'b1, 1'b0);
    tick();
    expect_all("wrap_next2", 32'h8, word(1), 32'h4, 32'h8, 1'b1, 1'b0);

    // Reset mid-operation overrides a simultaneous redirect and stall.
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h46);
    tick();
    expect_all("reset_mid", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    expect_all("reset_mid_run", 32'h4, word(0), 32'h0, 32'h4, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I 5-stage pipeline.
- Owns the program counter, which drives the instruction memory address combinationally. It takes the instruction word back the same cycle.
- Registers the instruction, PC and PC+4 into the IF/ID pipeline register for decode.
- Handles hazard-unit stall/flush and branch/jump redirects, and flags fetches outside instruction memory.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- IMEM_WORDS, 64, instruction memory depth in 32-bit words; word index >= IMEM_WORDS is out of range.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  hazard unit: replace IF/ID contents with bubble.
- redirect_valid  input  1  branch/jump taken; load PC from redirect_target.
- redirect_target  input  32  new PC byte address.
- imem_addr  output  32  byte address to instruction memory; equals pc_f.
- imem_rd  input  32  instruction word returned combinationally for imem_addr.
- pc_f  output  32  current fetch PC.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  IF/ID PC of instr_d.
- pc_plus4_d  output  32  IF/ID pc_d+4.
- valid_d  output  1  IF/ID holds a real instruction (0 = bubble).
- fault_d  output  1  instr_d fetch was out of range or from a misaligned redirect.

Behaviour:
- Reset, applied at a clock edge with reset=1, overrides all other inputs:
  - pc_f=RESET_PC, mis_f=0
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fault_d=0
- imem_addr = pc_f, purely combinational. The instruction is available the same cycle, so fetch latency is 1 cycle from PC to IF/ID.
- Next-PC priority, highest first:
  - reset
  - redirect_valid: pc_f <= {redirect_target[31:2],2'b00}; mis_f <= |redirect_target[1:0]
  - stall: pc_f and mis_f hold
  - otherwise: pc_f <= pc_f+4 (mod 2^32, so 32'hFFFFFFFC wraps to 0), mis_f <= 0
- Redirect overrides stall for the PC. A taken branch resolved downstream always wins over a load-use stall.
- Internal signal oob_f = (pc_f[31:2] >= IMEM_WORDS).
- IF/ID update priority, highest first:
  - reset
  - flush or redirect_valid: bubble (instr_d=NOP_INSTR, valid_d=0, fault_d=0; pc_d and pc_plus4_d hold). Redirect implies flush of the wrong-path fetch.
  - stall: all IF/ID outputs hold.
  - otherwise load:
    - instr_d = oob_f ? NOP_INSTR : imem_rd
    - pc_d = pc_f, pc_plus4_d = pc_f+4 (wrapping)
    - valid_d = 1, fault_d = oob_f | mis_f
- A faulting instruction has valid_d=1 and fault_d=1, so the downstream trap logic sees it in program order.
- No reset-mid-operation recovery state: reset on any cycle returns both PC and IF/ID to reset values at that edge.
- Simultaneous stall+flush without redirect: PC holds and IF/ID becomes a bubble.
- The stage holds no other state; no internal FSM beyond PC, mis_f and the IF/ID register.

Test Plan:
- Reset then run: reset=1 for 2 cycles, release, imem words 0..3 preloaded -> valid_d=0 during reset. pc_f sequence 0,4,8,C. instr_d trails pc_f by one cycle: cycle 1 after release gives pc_d=0, instr_d=word0, pc_plus4_d=4, valid_d=1.
- Stall: assert stall for 3 cycles with pc_f=8 -> pc_f stays 8, instr_d/pc_d=4 stay constant. Deassert -> pc_f 0xC next, no instruction lost or duplicated.
- Redirect under stall: pc_f=0x10, stall=1, redirect_valid=1, target=0x40 in the same cycle -> next pc_f=0x40, valid_d=0, instr_d=0x00000013. The following cycle pc_d=0x40, valid_d=1.
- Flush only: flush=1 with pc_f=0x20 -> IF/ID bubble (valid_d=0), pc_f=0x24 next. No redirect occurs.
- Misaligned and out-of-range fetches:
  - redirect target 0x46 -> pc_f=0x44, next IF/ID fault_d=1. The following sequential fetch has fault_d=0.
  - redirect target 0x100 (word 64) -> instr_d=NOP_INSTR, valid_d=1, fault_d=1.
- Wrap: redirect target 0xFFFFFFFC -> fault_d=1 (out of range), pc_plus4_d=0, and the next pc_f=0x00000000.
